// File: rtl/cmlk_3d_img_pkg.sv
// Shared types and field positions for the framed-image unpacker.
// StChk exists only when CMLK_3D_IMG_UNPACK_CHKSUM_EN is defined.
package cmlk_3d_img_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

    localparam int unsigned SYNC_MSB = 31;
    localparam int unsigned SYNC_LSB = 16;
    localparam int unsigned TYPE_MSB = 15;
    localparam int unsigned TYPE_LSB = 14;
    localparam int unsigned LEN_MSB  = 23;
    localparam int unsigned LEN_LSB  = 0;

`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
    typedef enum logic [2:0] {StHunt, StLen, StLoad, StEmitLo, StEmitHi, StChk} state_e;
`else
    typedef enum logic [2:0] {StHunt, StLen, StLoad, StEmitLo, StEmitHi} state_e;
`endif

endpackage

// File: rtl/cmlk_3d_img_unpack.sv
// Unpacks framed 32-bit FIFO words into a 16-bit sample stream, low half first.
// Define CMLK_3D_IMG_UNPACK_CHKSUM_EN to expect and check an XOR trailer word per frame.
module cmlk_3d_img_unpack
    import cmlk_3d_img_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter logic [23:0] MAX_LEN   = 24'd65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_rden,
    input  logic        rd_en,
    output logic [15:0] sample_out,
    output logic        sample_vld,
    input  logic        sample_rdy,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic [1:0]  frame_type_o,
    output logic        len_err,
    output logic        chk_err,
    output logic [15:0] drop_cnt
);

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        vld_q, vld_d;
    logic [1:0]  type_q, type_d;
    logic [1:0]  ftype_q, ftype_d;
    logic [15:0] drop_q, drop_d;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        sync_hit;
    logic [23:0] len_field;
    logic        len_ok;

    assign sync_hit  = fifo_rddata[SYNC_MSB:SYNC_LSB] == SYNC_WORD;
    assign len_field = fifo_rddata[LEN_MSB:LEN_LSB];
    assign len_ok    = (len_field != 24'd0) && (len_field <= MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHunt;
            cnt_q   <= '0;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            type_q  <= '0;
            ftype_q <= '0;
            drop_q  <= '0;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            type_q  <= type_d;
            ftype_q <= ftype_d;
            drop_q  <= drop_d;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHunt:   if (rd_en && !fifo_empty && sync_hit) state_d = StLen;
            StLen:    if (!fifo_empty) state_d = len_ok ? StLoad : StHunt;
            StLoad:   if (!fifo_empty) state_d = StEmitLo;
            StEmitLo: if (sample_rdy) state_d = StEmitHi;
            StEmitHi: begin
                if (sample_rdy) begin
                    if (cnt_q != 24'd0) begin
                        state_d = StLoad;
                    end else begin
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
                        state_d = StChk;
`else
                        state_d = StHunt;
`endif
                    end
                end
            end
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
            StChk:    if (!fifo_empty) state_d = StHunt;
`endif
            default:  state_d = StHunt;
        endcase
    end

    // Pop strobe and pulses are combinational so they line up with the pop / last transfer.
    always_comb begin
        fifo_rden     = 1'b0;
        frame_start_o = 1'b0;
        frame_end_o   = 1'b0;
        len_err       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StHunt: fifo_rden = rd_en && !fifo_empty;
                StLen: begin
                    fifo_rden     = !fifo_empty;
                    frame_start_o = !fifo_empty && len_ok;
                    len_err       = !fifo_empty && !len_ok;
                end
                StLoad: fifo_rden = !fifo_empty;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
                StChk: begin
                    fifo_rden   = !fifo_empty;
                    frame_end_o = !fifo_empty;
                end
`else
                StEmitHi: frame_end_o = sample_rdy && (cnt_q == 24'd0);
`endif
                default: ;
            endcase
        end
    end

`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
    assign chk_err = !rst && (state_q == StChk) && !fifo_empty && (fifo_rddata != sum_q);
`else
    assign chk_err = 1'b0;
`endif

    // The hold register shifts its high half down so sample_out is always hold_q[15:0].
    always_comb begin
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        vld_d   = vld_q;
        type_d  = type_q;
        ftype_d = ftype_q;
        drop_d  = drop_q;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            StHunt: begin
                if (rd_en && !fifo_empty) begin
                    if (sync_hit) begin
                        type_d = fifo_rddata[TYPE_MSB:TYPE_LSB];
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            StLen: begin
                if (!fifo_empty && len_ok) begin
                    cnt_d   = len_field;
                    ftype_d = type_q;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (!fifo_empty) begin
                    hold_d = fifo_rddata;
                    vld_d  = 1'b1;
                    if (cnt_q != 24'd0) cnt_d = cnt_q - 24'd1;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
                    sum_d  = sum_q ^ fifo_rddata;
`endif
                end
            end
            StEmitLo: if (sample_rdy) hold_d = {16'h0000, hold_q[31:16]};
            StEmitHi: if (sample_rdy) vld_d = 1'b0;
            default: ;
        endcase
    end

    assign sample_out   = hold_q[15:0];
    assign sample_vld   = vld_q;
    assign frame_type_o = ftype_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_cmlk_3d_img_unpack.sv
// Self-checking bench for cmlk_3d_img_unpack: directed frames plus randomized packet streams.
// Expectations follow CMLK_3D_IMG_UNPACK_CHKSUM_EN when it is defined.
module tb_cmlk_3d_img_unpack;

    localparam logic [15:0] SYNC = 16'hA55A;
    localparam int unsigned MAXL = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fifo_rddata;
    logic        fifo_empty;
    logic        fifo_rden;
    logic        rd_en;
    logic [15:0] sample_out;
    logic        sample_vld;
    logic        sample_rdy;
    logic        frame_start_o;
    logic        frame_end_o;
    logic [1:0]  frame_type_o;
    logic        len_err;
    logic        chk_err;
    logic [15:0] drop_cnt;

    cmlk_3d_img_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rddata  (fifo_rddata),
        .fifo_empty   (fifo_empty),
        .fifo_rden    (fifo_rden),
        .rd_en        (rd_en),
        .sample_out   (sample_out),
        .sample_vld   (sample_vld),
        .sample_rdy   (sample_rdy),
        .frame_start_o(frame_start_o),
        .frame_end_o  (frame_end_o),
        .frame_type_o (frame_type_o),
        .len_err      (len_err),
        .chk_err      (chk_err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model and stimulus controls
    logic [31:0] fifo_q[$];
    int          force_empty_cnt = 0;
    int          rdy_mode = 0;
    int          rdy_idx = 0;
    int          cyc = 0;

    // Observations
    logic [15:0] got_s[$];
    logic [1:0]  got_t[$];
    int          xfer_cyc[$];
    int          pop_cyc[$];
    int          n_start, n_end, n_end_xfer, n_len, n_chk, n_chk_end, bad_pop, bad_hold;
    logic        prev_stall;
    logic [15:0] prev_out;

    // Reference expectations
    logic [15:0] exp_s[$];
    logic [1:0]  exp_t[$];
    int          exp_drop, exp_len, exp_chk, exp_frames;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        fifo_empty  = (force_empty_cnt > 0) || (fifo_q.size() == 0);
        fifo_rddata = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic clear_mon();
        got_s.delete(); got_t.delete(); xfer_cyc.delete(); pop_cyc.delete();
        exp_s.delete(); exp_t.delete();
        n_start = 0; n_end = 0; n_end_xfer = 0; n_len = 0; n_chk = 0; n_chk_end = 0;
        bad_pop = 0; bad_hold = 0; prev_stall = 1'b0; prev_out = '0;
        exp_drop = 0; exp_len = 0; exp_chk = 0; exp_frames = 0;
    endtask

    // One clock: observe at the falling edge, then pop and re-drive just after the rising edge.
    task automatic step();
        logic        pop;
        logic [31:0] dummy;
        @(negedge clk);
        cyc++;
        if (fifo_rden && fifo_empty) bad_pop++;
        if (prev_stall && (sample_vld !== 1'b1 || sample_out !== prev_out)) bad_hold++;
        prev_stall = sample_vld && !sample_rdy;
        prev_out   = sample_out;
        if (sample_vld && sample_rdy) begin
            got_s.push_back(sample_out);
            xfer_cyc.push_back(cyc);
        end
        if (frame_start_o) n_start++;
        if (frame_end_o) begin
            n_end++;
            got_t.push_back(frame_type_o);
            if (sample_vld && sample_rdy) n_end_xfer++;
        end
        if (len_err) n_len++;
        if (chk_err) begin
            n_chk++;
            if (frame_end_o) n_chk_end++;
        end
        pop = fifo_rden;
        if (pop) pop_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) dummy = fifo_q.pop_front();
        if (force_empty_cnt > 0) force_empty_cnt--;
        rdy_idx++;
        case (rdy_mode)
            1:       sample_rdy = 1'($urandom_range(0, 1));
            2:       sample_rdy = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
            default: sample_rdy = 1'b1;
        endcase
        upd();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_vld", sample_vld, 1'b0);
        chk("rst_out", sample_out, 16'h0);
        chk("rst_type", frame_type_o, 2'd0);
        chk("rst_drop", drop_cnt, 16'h0);
        chk("rst_rden", fifo_rden, 1'b0);
        chk("rst_pulses", {frame_start_o, frame_end_o, len_err, chk_err}, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        upd();
    endtask

    task automatic push_frame_a(input logic [31:0] trailer, input bit bad);
        fifo_q.push_back(32'hA55A_4000);
        fifo_q.push_back(32'h0000_0002);
        fifo_q.push_back(32'h0002_0001);
        fifo_q.push_back(32'h0004_0003);
        exp_s.push_back(16'd1); exp_s.push_back(16'd2);
        exp_s.push_back(16'd3); exp_s.push_back(16'd4);
        exp_t.push_back(2'd1);
        exp_frames++;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
        fifo_q.push_back(trailer);
        if (bad) exp_chk++;
`else
        if (bad || trailer != 32'h0) exp_chk += 0;
`endif
        upd();
    endtask

    task automatic push_frame(input logic [1:0] t, input int n, input bit bad);
        logic [31:0] w;
        logic [31:0] x;
        x = '0;
        fifo_q.push_back({SYNC, t, 14'($urandom)});
        fifo_q.push_back({8'($urandom), 24'(n)});
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            x ^= w;
            exp_s.push_back(w[15:0]);
            exp_s.push_back(w[31:16]);
        end
        exp_t.push_back(t);
        exp_frames++;
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
        fifo_q.push_back(bad ? ~x : x);
        if (bad) exp_chk++;
`else
        if (bad) x = ~x;
`endif
        upd();
    endtask

    task automatic push_garbage(input logic [31:0] w_in);
        logic [31:0] w;
        w = w_in;
        if (w[31:16] == SYNC) w[31] = ~w[31];
        fifo_q.push_back(w);
        exp_drop++;
        upd();
    endtask

    task automatic push_len_err(input logic [23:0] n);
        fifo_q.push_back({SYNC, 2'($urandom), 14'h0});
        fifo_q.push_back({8'($urandom), n});
        exp_len++;
        upd();
    endtask

    task automatic run(input string name);
        int k = 0;
        while (k < 5000 && !(fifo_q.size() == 0 && got_s.size() >= exp_s.size())) begin
            step();
            k++;
        end
        repeat (4) step();
        chk({name, ":done"}, k < 5000, 1'b1);
    endtask

    task automatic compare_all(input string name);
        logic [63:0] v;
        chk({name, ":nsamp"}, got_s.size(), exp_s.size());
        foreach (exp_s[i]) begin
            v = (i < got_s.size()) ? 64'(got_s[i]) : 64'hx;
            chk($sformatf("%s:s%0d", name, i), v, exp_s[i]);
        end
        chk({name, ":nstart"}, n_start, exp_frames);
        chk({name, ":nend"}, n_end, exp_frames);
        foreach (exp_t[i]) begin
            v = (i < got_t.size()) ? 64'(got_t[i]) : 64'hx;
            chk($sformatf("%s:type%0d", name, i), v, exp_t[i]);
        end
`ifdef CMLK_3D_IMG_UNPACK_CHKSUM_EN
        chk({name, ":end_xfer"}, n_end_xfer, 0);
`else
        chk({name, ":end_xfer"}, n_end_xfer, exp_frames);
`endif
        chk({name, ":len_err"}, n_len, exp_len);
        chk({name, ":chk_err"}, n_chk, exp_chk);
        chk({name, ":chk_with_end"}, n_chk_end, exp_chk);
        chk({name, ":drop"}, drop_cnt, exp_drop);
        chk({name, ":pop_empty"}, bad_pop, 0);
        chk({name, ":hold"}, bad_hold, 0);
    endtask

    initial begin
        int r;
        int k;
        rd_en = 1'b1;
        sample_rdy = 1'b1;
        upd();
        clear_mon();

        // Reset state
        do_reset();

        // Frame A, latency pop -> low at +1, high at +2
        clear_mon();
        push_frame_a(32'h0006_0002, 1'b0);
        run("frame_a");
        compare_all("frame_a");
        chk("lat_lo", (pop_cyc.size() > 2 && xfer_cyc.size() > 0) ? xfer_cyc[0] - pop_cyc[2] : -1, 1);
        chk("lat_hi", (xfer_cyc.size() > 1) ? xfer_cyc[1] - xfer_cyc[0] : -1, 1);

        // Garbage then Frame A
        do_reset();
        clear_mon();
        push_garbage(32'h1234_5678);
        push_garbage(32'hDEAD_BEEF);
        push_frame_a(32'h0006_0002, 1'b0);
        run("garbage");
        compare_all("garbage");

        // Length errors
        do_reset();
        clear_mon();
        push_len_err(24'd0);
        fifo_q.push_back(32'hA55A_0000);
        fifo_q.push_back(32'h0100_0000);
        exp_len++;
        push_len_err(24'(MAXL + 1));
        run("len_err");
        compare_all("len_err");

        // Backpressure 1,0,0,1 and forced-empty FIFO mid-frame
        do_reset();
        clear_mon();
        rdy_mode = 2;
        push_frame_a(32'h0006_0002, 1'b0);
        k = 0;
        while (got_s.size() < 1 && k < 100) begin step(); k++; end
        force_empty_cnt = 3;
        upd();
        run("bp");
        compare_all("bp");
        rdy_mode = 0;

        // Checksum: good trailer then bad trailer
        do_reset();
        clear_mon();
        push_frame_a(32'h0006_0002, 1'b0);
        push_frame_a(32'h0000_0000, 1'b1);
        run("chksum");
        compare_all("chksum");

        // Reset after sample 2, then rd_en gating
        do_reset();
        clear_mon();
        push_frame_a(32'h0006_0002, 1'b0);
        k = 0;
        while (got_s.size() < 2 && k < 100) begin step(); k++; end
        do_reset();
        chk("mid_rst_no_end", n_end, 0);
        fifo_q.delete();
        rd_en = 1'b0;
        clear_mon();
        push_frame_a(32'h0006_0002, 1'b0);
        k = fifo_q.size();
        repeat (10) step();
        chk("rd_en0_pops", pop_cyc.size(), 0);
        chk("rd_en0_fifo", fifo_q.size(), k);
        rd_en = 1'b1;
        run("after_rst");
        compare_all("after_rst");

        // Randomized packet stream with random backpressure
        do_reset();
        clear_mon();
        rdy_mode = 1;
        for (int p = 0; p < 24; p++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                repeat ($urandom_range(1, 3)) push_garbage($urandom);
            end else if (r == 2) begin
                case ($urandom_range(0, 2))
                    0:       push_len_err(24'd0);
                    1:       push_len_err(24'(MAXL + 1));
                    default: push_len_err(24'hFFFFFF);
                endcase
            end else begin
                push_frame(2'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
            end
        end
        run("rand");
        compare_all("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
